diff_vector_harness: RTL and testbench

// Synthesizable successor to the fixed-vector fuzz testbench. It accepts stimulus

---
 rtl/diff_vector_harness_if.sv | 22 ++
 rtl/diff_vector_harness.sv | 172 +++++++++++++++++
 tb/tb_diff_vector_harness.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/diff_vector_harness_if.sv
// Stimulus stream plus the fan-out/fan-in bus to the two netlists under comparison.
// The harness is the slave; the vector source and DUT pair sit on the master side.
interface diff_vector_harness_if #(
    parameter int IN_W  = 83,
    parameter int OUT_W = 385
);
    logic             stim_valid;
    logic             stim_ready;
    logic [IN_W-1:0]  stim_data;
    logic [IN_W-1:0]  dut_in;
    logic [OUT_W-1:0] y_ref;
    logic [OUT_W-1:0] y_dut;

    modport master (
        output stim_valid, stim_data, y_ref, y_dut,
        input  stim_ready, dut_in
    );
    modport slave (
        input  stim_valid, stim_data, y_ref, y_dut,
        output stim_ready, dut_in
    );
endinterface

// File: rtl/diff_vector_harness.sv
// Differential equivalence harness: feeds one vector at a time to two netlists,
// compares their outputs after a settle time and signs each output stream.

module dvh_misr #(
    parameter int              W     = 385,
    parameter int              SIG_W = 32,
    parameter logic [SIG_W-1:0] POLY = 32'h04C11DB7
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [W-1:0]     y_i,
    output logic [SIG_W-1:0] sig_o
);
    localparam int NCH = (W + SIG_W - 1) / SIG_W;

    logic [NCH*SIG_W-1:0] y_pad;
    logic [SIG_W-1:0]     fold;
    logic [SIG_W-1:0]     sig_q, sig_d;

    // Zero-pad to whole chunks, then XOR-compress to one signature-wide word.
    always_comb begin
        y_pad        = '0;
        y_pad[W-1:0] = y_i;
        fold         = '0;
        for (int c = 0; c < NCH; c++) fold = fold ^ y_pad[c*SIG_W +: SIG_W];
        sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ fold;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || clr_i) sig_q <= '0;
        else if (en_i)         sig_q <= sig_d;
    end

    assign sig_o = sig_q;
endmodule

module diff_vector_harness #(
    parameter int               IN_W   = 83,
    parameter int               OUT_W  = 385,
    parameter int               SIG_W  = 32,
    parameter logic [SIG_W-1:0] POLY   = 32'h04C11DB7,
    parameter int               SETTLE = 1,
    parameter int               CNT_W  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic [CNT_W-1:0]      num_vec_i,
    diff_vector_harness_if.slave  bus,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  mismatch_o,
    output logic [CNT_W-1:0]      mism_count_o,
    output logic [CNT_W-1:0]      first_mism_idx_o,
    output logic [CNT_W-1:0]      vec_count_o,
    output logic [SIG_W-1:0]      sig_ref_o,
    output logic [SIG_W-1:0]      sig_dut_o
);
    localparam int WC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_SAMPLE, S_DONE} state_t;

    state_t           state_q;
    logic             ready_q, busy_q, done_q, mism_q;
    logic [IN_W-1:0]  dut_in_q;
    logic [CNT_W-1:0] num_vec_q, vec_cnt_q, mism_cnt_q, first_q;
    logic [WC_W-1:0]  wait_q;

    logic             run_start, sample_en, fail;
    logic [CNT_W:0]   vec_next;

    assign run_start = start_i && (state_q == S_IDLE || state_q == S_DONE);
    assign sample_en = (state_q == S_SAMPLE);
    assign fail      = (bus.y_ref != bus.y_dut);
    assign vec_next  = {1'b0, vec_cnt_q} + 1'b1;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mism_q     <= 1'b0;
            dut_in_q   <= '0;
            num_vec_q  <= '0;
            vec_cnt_q  <= '0;
            mism_cnt_q <= '0;
            first_q    <= '1;
            wait_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        num_vec_q  <= num_vec_i;
                        vec_cnt_q  <= '0;
                        mism_cnt_q <= '0;
                        mism_q     <= 1'b0;
                        first_q    <= '1;
                        if (num_vec_i == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_LOAD;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end
                end
                S_LOAD: begin
                    if (bus.stim_valid) begin
                        dut_in_q <= bus.stim_data;
                        ready_q  <= 1'b0;
                        wait_q   <= '0;
                        state_q  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_q == WC_W'(SETTLE - 1)) state_q <= S_SAMPLE;
                    else                             wait_q  <= wait_q + 1'b1;
                end
                S_SAMPLE: begin
                    if (fail) begin
                        mism_q <= 1'b1;
                        if (mism_cnt_q != '1) mism_cnt_q <= mism_cnt_q + 1'b1;
                        if (!mism_q)          first_q    <= vec_cnt_q;
                    end
                    vec_cnt_q <= vec_next[CNT_W-1:0];
                    if (vec_next < {1'b0, num_vec_q}) begin
                        state_q <= S_LOAD;
                        ready_q <= 1'b1;
                    end else begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // One signature engine per output bus; index 0 is the reference side.
    logic [1:0][OUT_W-1:0] y_bus;
    logic [1:0][SIG_W-1:0] sig_bus;

    assign y_bus = {bus.y_dut, bus.y_ref};

    for (genvar g = 0; g < 2; g++) begin : g_misr
        dvh_misr #(.W(OUT_W), .SIG_W(SIG_W), .POLY(POLY)) u_misr (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .clr_i   (run_start),
            .en_i    (sample_en),
            .y_i     (y_bus[g]),
            .sig_o   (sig_bus[g])
        );
    end

    assign bus.stim_ready   = ready_q;
    assign bus.dut_in       = dut_in_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign mismatch_o       = mism_q;
    assign mism_count_o     = mism_cnt_q;
    assign first_mism_idx_o = first_q;
    assign vec_count_o      = vec_cnt_q;
    assign sig_ref_o        = sig_bus[0];
    assign sig_dut_o        = sig_bus[1];
endmodule

// File: tb/tb_diff_vector_harness.sv
// Directed bench for diff_vector_harness: run-level model plus literal expectations.
module tb_diff_vector_harness;
    localparam int          IN_W = 83, OUT_W = 385, SIG_W = 32, CNT_W = 16, SETTLE = 1;
    localparam logic [31:0] POLY = 32'h04C11DB7;

    logic              clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [CNT_W-1:0]  num_vec = '0;
    logic              busy, done, mismatch;
    logic [CNT_W-1:0]  mism_count, first_idx, vec_count;
    logic [SIG_W-1:0]  sig_ref, sig_dut;

    diff_vector_harness_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    diff_vector_harness #(
        .IN_W(IN_W), .OUT_W(OUT_W), .SIG_W(SIG_W), .POLY(POLY), .SETTLE(SETTLE), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .num_vec_i(num_vec), .bus(bus),
        .busy_o(busy), .done_o(done), .mismatch_o(mismatch), .mism_count_o(mism_count),
        .first_mism_idx_o(first_idx), .vec_count_o(vec_count),
        .sig_ref_o(sig_ref), .sig_dut_o(sig_dut)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // Run-level model state
    logic             m_busy = 0, m_done = 0, m_mism = 0;
    logic [CNT_W-1:0] m_num = '0, m_vec = '0, m_mcnt = '0, m_first = '1;
    logic [SIG_W-1:0] m_sref = '0, m_sdut = '0;
    logic [IN_W-1:0]  m_din = '0;
    int               m_cd = 0;
    int               run_id = 0, inj_idx = -1;
    logic             drv_en = 0, drv_tog = 0;

    function automatic logic [OUT_W-1:0] yfun(input logic [IN_W-1:0] x);
        logic [OUT_W-1:0] y;
        for (int i = 0; i < OUT_W; i++) y[i] = x[i % IN_W] ^ x[(i*7 + 3) % IN_W] ^ (i % 5 == 0);
        return y;
    endfunction

    function automatic logic [IN_W-1:0] word(input int run, input logic [CNT_W-1:0] k);
        logic [31:0] a, b, c;
        a = (32'(k) * 32'h9E3779B9) ^ 32'(run);
        b = 32'(k) * 3 + 32'(run);
        c = 32'(run) * 1000 + 32'(k);
        return {a, b[18:0], c};
    endfunction

    // Signature step straight from the definition: bit i of y lands on bit i mod SIG_W.
    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s, input logic [OUT_W-1:0] y);
        logic [SIG_W-1:0] f = '0;
        for (int i = 0; i < OUT_W; i++) f[i % SIG_W] = f[i % SIG_W] ^ y[i];
        return {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? POLY : '0) ^ f;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Netlist stand-ins: both compute f(dut_in); the DUT side may flip bit 384 on one vector.
    always_comb begin
        bus.y_ref = yfun(bus.dut_in);
        bus.y_dut = yfun(bus.dut_in);
        if (inj_idx == int'(m_vec)) bus.y_dut[OUT_W-1] = ~bus.y_dut[OUT_W-1];
    end

    // Source: offers the next word in order; junk on the data bus when not valid.
    always @(negedge clk) begin
        if (drv_en && (!drv_tog || !bus.stim_valid)) begin
            bus.stim_valid = 1'b1;
            bus.stim_data  = word(run_id, m_vec);
        end else begin
            logic [95:0] junk;
            junk = {$urandom, $urandom, $urandom};
            bus.stim_valid = 1'b0;
            bus.stim_data  = junk[IN_W-1:0];
        end
    end

    // Model: events seen at each rising edge, evaluated on pre-edge values.
    always @(posedge clk) begin
        logic [OUT_W-1:0] yr, yd;
        logic             was_busy;
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_mism = 0; m_num = '0; m_vec = '0; m_mcnt = '0;
            m_first = '1; m_sref = '0; m_sdut = '0; m_din = '0; m_cd = 0;
        end else begin
            was_busy = m_busy;
            if (m_cd > 0) begin
                m_cd--;
                if (m_cd == 0) begin
                    yr = yfun(m_din);
                    yd = yr;
                    if (inj_idx == int'(m_vec)) yd[OUT_W-1] = ~yd[OUT_W-1];
                    if (yr != yd) begin
                        if (!m_mism) m_first = m_vec;
                        m_mism = 1;
                        if (m_mcnt != '1) m_mcnt++;
                    end
                    m_sref = misr_step(m_sref, yr);
                    m_sdut = misr_step(m_sdut, yd);
                    m_vec++;
                    if (m_vec == m_num) begin m_busy = 0; m_done = 1; end
                end
            end
            if (start && !was_busy) begin
                m_num = num_vec; m_vec = '0; m_mcnt = '0; m_mism = 0; m_first = '1;
                m_sref = '0; m_sdut = '0;
                if (num_vec == '0) begin m_done = 1; m_busy = 0; end
                else               begin m_done = 0; m_busy = 1; end
            end
            if (bus.stim_valid && bus.stim_ready) begin
                m_din = word(run_id, m_vec);
                m_cd  = SETTLE + 1;
            end
        end
    end

    // Every cycle: all outputs against the model.
    always @(negedge clk) begin
        chk("ready",      bus.stim_ready, m_busy && m_cd == 0);
        chk("busy",       busy,           m_busy);
        chk("done",       done,           m_done);
        chk("mismatch",   mismatch,       m_mism);
        chk("mism_count", mism_count,     m_mcnt);
        chk("first_idx",  first_idx,      m_first);
        chk("vec_count",  vec_count,      m_vec);
        chk("sig_ref",    sig_ref,        m_sref);
        chk("sig_dut",    sig_dut,        m_sdut);
        chk("dut_in",     bus.dut_in,     m_din);
    end

    task automatic pulse_start(input logic [CNT_W-1:0] n);
        @(negedge clk);
        start   = 1'b1;
        num_vec = n;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int maxc, output int cyc);
        cyc = 0;
        while (!done && cyc < maxc) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s: done not seen within %0d cycles", nm, maxc);
        end
    endtask

    initial begin
        int cyc;
        bus.stim_valid = 1'b0;
        bus.stim_data  = '0;

        // Reset
        repeat (2) @(negedge clk);
        chk("t1_first_idx", first_idx, 16'hFFFF);
        chk("t1_ready", bus.stim_ready, 1'b0);
        chk("t1_vec", vec_count, 16'h0);
        chk("t1_sig", sig_dut, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Clean run of 4
        run_id = 1; drv_en = 1; drv_tog = 0;
        pulse_start(16'd4);
        wait_done("t2_done", 40, cyc);
        chk("t2_latency", 32'(cyc), 32'd12);
        chk("t2_vec", vec_count, 16'd4);
        chk("t2_mism", mismatch, 1'b0);
        chk("t2_sig_eq", sig_dut, sig_ref);

        // Bit 384 flipped on vector 2: difference enters as 1 and is shifted once more
        run_id = 2; inj_idx = 2;
        pulse_start(16'd4);
        wait_done("t3_done", 40, cyc);
        chk("t3_mcnt", mism_count, 16'd1);
        chk("t3_first", first_idx, 16'd2);
        chk("t3_sigdiff", sig_ref ^ sig_dut, 32'h2);
        inj_idx = -1;

        // Toggling valid
        run_id = 3; drv_tog = 1;
        pulse_start(16'd5);
        wait_done("t4_done", 80, cyc);
        chk("t4_vec", vec_count, 16'd5);
        chk("t4_din", bus.dut_in, word(3, 16'd4));
        drv_tog = 0;

        // Zero-length run, then start while busy
        @(negedge clk);
        start = 1'b1; num_vec = '0;
        @(negedge clk);
        start = 1'b0;
        chk("t5_done", done, 1'b1);
        chk("t5_vec", vec_count, 16'd0);
        chk("t5_first", first_idx, 16'hFFFF);
        run_id = 5;
        pulse_start(16'd2);
        repeat (2) @(negedge clk);
        start = 1'b1; num_vec = 16'd7;
        @(negedge clk);
        start = 1'b0;
        wait_done("t5b_done", 40, cyc);
        chk("t5b_vec", vec_count, 16'd2);

        // Reset while vector 1 is settling
        run_id = 6;
        pulse_start(16'd4);
        cyc = 0;
        while (!(m_vec == 16'd1 && m_cd == SETTLE + 1) && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("t6_reached_wait", busy, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t6_busy", busy, 1'b0);
        chk("t6_first", first_idx, 16'hFFFF);
        cyc = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) cyc++;
        end
        chk("t6_no_done", 32'(cyc), 32'd0);
        run_id = 7;
        pulse_start(16'd4);
        wait_done("t6b_done", 40, cyc);
        chk("t6b_latency", 32'(cyc), 32'd12);
        chk("t6b_vec", vec_count, 16'd4);
        chk("t6b_sig_eq", sig_dut, sig_ref);

        drv_en = 0;
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
